// File: rtl/e203_icb_sram_resp_if.sv
// ICB command/response bundle between an LSU-side requester (master) and an
// SRAM-backed responder (slave).
interface e203_icb_sram_resp_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic [1:0]        icb_cmd_size;
    logic              icb_cmd_excl;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic              icb_rsp_excl_ok;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_cmd_size, icb_cmd_excl, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
               icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_cmd_size, icb_cmd_excl, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
               icb_rsp_rdata
    );
endinterface

// File: rtl/e203_icb_sram_resp.sv
// ICB responder in front of a single-port synchronous SRAM.
// Accepts byte/half/word reads and masked writes, keeps up to two responses
// outstanding (one-cycle pending stage + 2-entry FIFO) and hosts the lr/sc
// reservation monitor.
// Optional feature macro: E203_ICB_SRAM_EXCL_EN enables the reservation
// monitor; without it exclusive accesses behave as normal accesses and
// exclusive writes report excl_ok = ~err.
module e203_icb_sram_resp #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              SRAM_AW   = 14,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h9000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_icb_sram_resp_if.slave  icb,
    input  logic                 excl_clr,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [SRAM_AW-1:0]   ram_addr,
    output logic [DW/8-1:0]      ram_wem,
    output logic [DW-1:0]        ram_din,
    input  logic [DW-1:0]        ram_dout
);

    localparam int RW    = SRAM_AW + 2;   // log2 of region size in bytes
    localparam int RSP_W = DW + 2;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          excl_ok;
    } rsp_ent_t;

    // Outstanding-response bookkeeping
    logic [1:0] cnt_q, cnt_d;

    // Pending stage: the access issued to the SRAM last cycle
    logic pend_vld_q, pend_vld_d;
    logic pend_err_q, pend_err_d;
    logic pend_excl_ok_q, pend_excl_ok_d;
    logic pend_read_q, pend_read_d;

    // Two-entry response FIFO
    rsp_ent_t   fifo_q [2];
    rsp_ent_t   fifo_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;

    // Combinational decode / handshake signals
    logic     cmd_ready_s;
    logic     cmd_hs_s;
    logic     hit_s;
    logic     mis_s;
    logic     err_s;
    logic     excl_ok_s;
    logic     excl_fail_s;
    logic     fifo_empty_s;
    logic     rsp_valid_s;
    logic     rsp_hs_s;
    logic     push_s;
    logic     pop_s;
    rsp_ent_t pend_ent_s;
    rsp_ent_t rsp_ent_s;

    assign cmd_ready_s  = (cnt_q < 2'd2);
    assign cmd_hs_s     = icb.icb_cmd_valid & cmd_ready_s;
    assign fifo_empty_s = (fifo_cnt_q == 2'd0);

    // Address range and alignment decode of the offered command
    always_comb begin
        hit_s = (icb.icb_cmd_addr[AW-1:RW] == BASE_ADDR[AW-1:RW]);
        case (icb.icb_cmd_size)
            2'd0:    mis_s = 1'b0;
            2'd1:    mis_s = icb.icb_cmd_addr[0];
            2'd2:    mis_s = (icb.icb_cmd_addr[1:0] != 2'b00);
            default: mis_s = 1'b1;
        endcase
        err_s = ~hit_s | mis_s;
    end

`ifdef E203_ICB_SRAM_EXCL_EN
    logic          resv_vld_q, resv_vld_d;
    logic [AW-3:0] resv_addr_q, resv_addr_d;
    logic          resv_match_s;
    logic          resv_hit_s;

    assign resv_match_s = (resv_addr_q == icb.icb_cmd_addr[AW-1:2]);
    assign resv_hit_s   = resv_vld_q & resv_match_s;

    // Exclusive-store outcome: a store without a live matching reservation is suppressed
    always_comb begin
        if (icb.icb_cmd_excl & ~icb.icb_cmd_read) begin
            excl_fail_s = ~resv_hit_s;
            excl_ok_s   = resv_hit_s & ~err_s;
        end else begin
            excl_fail_s = 1'b0;
            excl_ok_s   = 1'b0;
        end
    end

    // Reservation update; a new lr beats a simultaneous kill since it is younger
    always_comb begin
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        if (cmd_hs_s & icb.icb_cmd_excl & icb.icb_cmd_read & ~err_s) begin
            resv_vld_d  = 1'b1;
            resv_addr_d = icb.icb_cmd_addr[AW-1:2];
        end else if (excl_clr) begin
            resv_vld_d = 1'b0;
        end else if (cmd_hs_s & ~icb.icb_cmd_read &
                     (icb.icb_cmd_excl | (~err_s & resv_match_s))) begin
            resv_vld_d = 1'b0;
        end else begin
            resv_vld_d = resv_vld_q;
        end
    end

    // Reservation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_vld_q  <= 1'b0;
            resv_addr_q <= {(AW-2){1'b0}};
        end else begin
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
        end
    end
`else
    logic unused_excl_clr_s;
    assign unused_excl_clr_s = excl_clr;

    // Without the monitor every exclusive store goes through and succeeds unless it errors
    always_comb begin
        excl_fail_s = 1'b0;
        if (icb.icb_cmd_excl & ~icb.icb_cmd_read) begin
            excl_ok_s = ~err_s;
        end else begin
            excl_ok_s = 1'b0;
        end
    end
`endif

    // SRAM is driven straight from the accepted command in the accept cycle
    assign ram_cs   = cmd_hs_s & ~err_s & ~excl_fail_s;
    assign ram_we   = ~icb.icb_cmd_read;
    assign ram_addr = icb.icb_cmd_addr[RW-1:2];
    assign ram_wem  = icb.icb_cmd_wmask;
    assign ram_din  = icb.icb_cmd_wdata;

    // Response source: FIFO head if anything is queued, else the pending stage (bypass)
    always_comb begin
        pend_ent_s.rdata   = (pend_read_q & ~pend_err_q) ? ram_dout : {DW{1'b0}};
        pend_ent_s.err     = pend_err_q;
        pend_ent_s.excl_ok = pend_excl_ok_q;
        if (!fifo_empty_s) begin
            rsp_ent_s = fifo_q[rd_ptr_q];
        end else begin
            rsp_ent_s = pend_ent_s;
        end
    end

    assign rsp_valid_s = ~fifo_empty_s | pend_vld_q;
    assign rsp_hs_s    = rsp_valid_s & icb.icb_rsp_ready;
    // The pending entry skips the FIFO only when it is consumed directly this cycle
    assign push_s      = pend_vld_q & ~(fifo_empty_s & icb.icb_rsp_ready);
    assign pop_s       = rsp_hs_s & ~fifo_empty_s;

    assign icb.icb_cmd_ready   = cmd_ready_s;
    assign icb.icb_rsp_valid   = rsp_valid_s;
    assign icb.icb_rsp_err     = rsp_ent_s.err;
    assign icb.icb_rsp_excl_ok = rsp_ent_s.excl_ok;
    assign icb.icb_rsp_rdata   = rsp_ent_s.rdata;

    // Next-state for the outstanding count and the pending stage
    always_comb begin
        case ({cmd_hs_s, rsp_hs_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        pend_vld_d = cmd_hs_s;
        if (cmd_hs_s) begin
            pend_err_d     = err_s;
            pend_excl_ok_d = excl_ok_s;
            pend_read_d    = icb.icb_cmd_read;
        end else begin
            pend_err_d     = pend_err_q;
            pend_excl_ok_d = pend_excl_ok_q;
            pend_read_d    = pend_read_q;
        end
    end

    // Next-state for the response FIFO
    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = pend_ent_s;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State registers; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= 2'd0;
            pend_vld_q     <= 1'b0;
            pend_err_q     <= 1'b0;
            pend_excl_ok_q <= 1'b0;
            pend_read_q    <= 1'b0;
            fifo_q[0]      <= {RSP_W{1'b0}};
            fifo_q[1]      <= {RSP_W{1'b0}};
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            cnt_q          <= cnt_d;
            pend_vld_q     <= pend_vld_d;
            pend_err_q     <= pend_err_d;
            pend_excl_ok_q <= pend_excl_ok_d;
            pend_read_q    <= pend_read_d;
            fifo_q[0]      <= fifo_d[0];
            fifo_q[1]      <= fifo_d[1];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

endmodule

// File: doc/e203_icb_sram_resp.md
Name: e203_icb_sram_resp

Overview:
- ICB responder (target) that terminates the command/response channels issued by the LSU address-generation path and drives a single-port, word-wide, synchronous SRAM macro.
- Performs byte/half/word reads and masked writes with one-cycle SRAM read latency.
- Buffers up to 2 responses so command acceptance continues under response backpressure.
- Implements the exclusive-reservation monitor behind lr/sc (cmd_excl / rsp_excl_ok).

Parameters:
- AW, 32: ICB address width.
- DW, 32: data width; fixed 32, mask width DW/8.
- SRAM_AW, 14: SRAM word-address bits; region size is 2^(SRAM_AW+2) bytes.
- BASE_ADDR, 32'h9000_0000: region base; must be aligned to the region size.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data, lane-aligned
- icb_cmd_wmask  in  DW/8  byte write enables
- icb_cmd_size  in  2  0=byte, 1=half, 2=word
- icb_cmd_excl  in  1  exclusive access (lr/sc)
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_err  out  1  bus error
- icb_rsp_excl_ok  out  1  exclusive store succeeded
- icb_rsp_rdata  out  DW  raw 32-bit word read data; the requester aligns and extends it
- excl_clr  in  1  kill reservation (trap or xRET)
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_addr  out  SRAM_AW  SRAM word address
- ram_wem  out  DW/8  SRAM byte write mask
- ram_din  out  DW  SRAM write data
- ram_dout  in  DW  SRAM read data, valid one cycle after ram_cs with ram_we=0

Behaviour:
- Reset values: all registered state clears. Outstanding count=0, FIFO empty, resv_vld=0, pending stage empty.
  - Outputs after reset: icb_rsp_valid=0, icb_cmd_ready=1, ram_cs=0.
- Outstanding count cnt (0..2) = pending stage + FIFO entries.
  - icb_cmd_ready = (cnt<2), taken from registered state only; no comb path from icb_rsp_ready.
  - cnt +1 on command handshake, -1 on response handshake; both in the same cycle leaves cnt unchanged.
- Decode on accept (cycle N):
  - hit = addr within [BASE_ADDR, BASE_ADDR+2^(SRAM_AW+2)).
  - mis = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | size==3.
  - err = ~hit | mis.
- SRAM drive, combinational in cycle N: ram_cs = handshake & ~err & ~excl_fail; ram_we = ~read; ram_addr = addr[SRAM_AW+1:2]; ram_wem = wmask; ram_din = wdata.
- Pending stage register, captured at N: err, excl_ok, is_read.
  - At N+1 the response {rdata = is_read&~err ? ram_dout : 0, err, excl_ok} is written into the 2-entry FIFO.
  - FIFO-empty bypass is allowed if cycle-equivalent: first response is visible at N+1.
- Response latency: icb_rsp_valid rises at N+1 when the FIFO is empty. Order is strictly preserved.
- While icb_rsp_valid=1 & icb_rsp_ready=0, response outputs hold stable.
- Exclusive monitor (see Optional Feature):
  - Excl read with ~err sets resv_vld=1 and resv_addr=addr[AW-1:2].
  - Excl write: success iff resv_vld & resv_addr==addr[AW-1:2] & ~err.
    - Success: SRAM write performed, excl_ok=1.
    - Failure: no SRAM write (excl_fail), excl_ok=0, err unchanged by failure.
    - Every excl write clears resv_vld, including failing and erroring ones.
  - A non-excl write with ~err whose word address matches resv_addr clears resv_vld.
  - excl_clr clears resv_vld.
  - If excl_clr coincides with an excl read accept, the set wins (the new lr is younger).
- Errored accesses never assert ram_cs. They still occupy a FIFO slot and return err=1, rdata=0, excl_ok=0.
- Async reset mid-operation drops all in-flight responses; the requester is reset too.

Optional Feature:
- Macro: E203_ICB_SRAM_EXCL_EN.
- Defined: exclusive monitor as specified above.
- Undefined:
  - No reservation registers; excl_clr is ignored.
  - Excl reads behave as normal reads.
  - Excl writes always execute and return excl_ok = ~err.

Test Plan:
- Word write 0xDEADBEEF to BASE+0x10, mask 4'hF, then word read of BASE+0x10 -> read rsp at accept+1 with rdata=0xDEADBEEF, err=0.
- Byte write 0xAA at BASE+0x13 (wdata=0xAA000000, wmask=4'b1000), then word read -> rdata=0xAAADBEEF.
- Hold rsp_ready=0 and issue 3 reads -> cmd_ready deasserts after 2 accepts. Release rsp_ready -> 3 responses in order, no loss, no duplicates.
- Half read at BASE+0x1 and word read at BASE+2^(SRAM_AW+2) -> both return err=1, rdata=0; ram_cs never asserted.
- lr at BASE+0x20, then sc 0x5 at BASE+0x20 -> excl_ok=1 and memory=5. A second sc -> excl_ok=0 and memory unchanged.
- lr at BASE+0x20, normal write to BASE+0x22, then sc -> excl_ok=0. lr, excl_clr pulse, then sc -> excl_ok=0 (only with the macro defined).
